// File: rtl/ldiv_result_buffer.sv
// ldiv_result_buffer
// Purpose : result FIFO behind the fixed-latency long divider. It absorbs
//           divider results while the consumer stalls, presents them on a
//           ready/valid master port, and returns a credit (issue_ok) so the
//           issuer never starts more work than the FIFO can hold.
// Latency : a push at cycle N shows on m_valid/m_quotient/m_remainder at N+1.
//           There is no empty bypass.
// Backpressure: m_ready low holds the head entry stable. issue_ok falls when
//           stored results plus results still inside the divider reach DEPTH.
// Optional feature: define LDIV_RESULT_BUFFER_ERR_EN to get sticky err flags
//           and saturating in-flight accounting. Without it, err is 3'b000 and
//           the counters wrap.
// Ports   : clk, resetb (async, active-low)
//           issue_in / issue_ok            - issuer handshake (credit)
//           div_quotient_in, div_remainder_in, div_valid_in - divider output
//           m_quotient, m_remainder, m_valid, m_ready       - consumer port
//           count, in_flight, err          - status
module ldiv_result_buffer #(
  parameter int NUMERATOR_WIDTH = 23,
  parameter int QUOTIENT_WIDTH  = 23,
  parameter int DEPTH           = 16,
  localparam int CW             = $clog2(DEPTH + 1)
) (
  input  logic                       clk,
  input  logic                       resetb,
  input  logic                       issue_in,
  output logic                       issue_ok,
  input  logic [QUOTIENT_WIDTH-1:0]  div_quotient_in,
  input  logic [NUMERATOR_WIDTH-1:0] div_remainder_in,
  input  logic                       div_valid_in,
  output logic [QUOTIENT_WIDTH-1:0]  m_quotient,
  output logic [NUMERATOR_WIDTH-1:0] m_remainder,
  output logic                       m_valid,
  input  logic                       m_ready,
  output logic [CW-1:0]              count,
  output logic [CW-1:0]              in_flight,
  output logic [2:0]                 err
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [QUOTIENT_WIDTH-1:0]  mem_q [DEPTH];
  logic [NUMERATOR_WIDTH-1:0] mem_r [DEPTH];

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] rd_ptr_inc;
  logic [AW-1:0] wr_ptr_inc;

  logic          pop;
  logic          full;
  logic          push_acc;
  logic [CW-1:0] count_nxt;
  logic [CW-1:0] in_flight_nxt;
  logic [CW:0]   occupancy;

  // DEPTH is a power of two, so the natural AW-bit wrap is modulo DEPTH.
  assign rd_ptr_inc = rd_ptr + AW'(1);
  assign wr_ptr_inc = wr_ptr + AW'(1);

  assign pop  = m_valid & m_ready;
  assign full = (count == CW'(DEPTH));
  // On a full FIFO a push can still go in if the head leaves in the same cycle.
  assign push_acc = div_valid_in & (~full | pop);

  // The credit is computed from registers only, so issue_in has no
  // combinational path back to issue_ok.
  assign occupancy = {1'b0, count} + {1'b0, in_flight};
  assign issue_ok  = (occupancy < (CW+1)'(DEPTH));

  always_comb begin
    count_nxt = count;
    case ({push_acc, pop})
      2'b10:   count_nxt = count + CW'(1);
      2'b01:   count_nxt = count - CW'(1);
      default: count_nxt = count;
    endcase
  end

  always_comb begin
    in_flight_nxt = in_flight;
    case ({issue_in, div_valid_in})
`ifdef LDIV_RESULT_BUFFER_ERR_EN
      2'b10:   if (in_flight != CW'(DEPTH)) in_flight_nxt = in_flight + CW'(1);
      2'b01:   if (in_flight != CW'(0))     in_flight_nxt = in_flight - CW'(1);
`else
      2'b10:   in_flight_nxt = in_flight + CW'(1);
      2'b01:   in_flight_nxt = in_flight - CW'(1);
`endif
      default: in_flight_nxt = in_flight;
    endcase
  end

  // Storage has no reset; the contents are only meaningful below count.
  always_ff @(posedge clk) begin
    if (push_acc) begin
      mem_q[wr_ptr] <= div_quotient_in;
      mem_r[wr_ptr] <= div_remainder_in;
    end
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      in_flight <= '0;
      m_valid   <= 1'b0;
    end else begin
      if (push_acc) wr_ptr <= wr_ptr_inc;
      if (pop)      rd_ptr <= rd_ptr_inc;
      count     <= count_nxt;
      in_flight <= in_flight_nxt;
      m_valid   <= (count_nxt != CW'(0));
    end
  end

  // Head register. After a pop, the next entry comes from memory unless the
  // FIFO held a single entry. In that case the only candidate is the push
  // arriving in the same cycle, which is not in memory yet.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      m_quotient  <= '0;
      m_remainder <= '0;
    end else if (pop) begin
      if (count == CW'(1)) begin
        if (push_acc) begin
          m_quotient  <= div_quotient_in;
          m_remainder <= div_remainder_in;
        end
      end else begin
        m_quotient  <= mem_q[rd_ptr_inc];
        m_remainder <= mem_r[rd_ptr_inc];
      end
    end else if (count == CW'(0) && push_acc) begin
      m_quotient  <= div_quotient_in;
      m_remainder <= div_remainder_in;
    end
  end

`ifdef LDIV_RESULT_BUFFER_ERR_EN
  logic [2:0] err_q;

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      err_q <= 3'b000;
    end else begin
      if (div_valid_in & ~push_acc)                          err_q[0] <= 1'b1;
      if (div_valid_in & ~issue_in & (in_flight == CW'(0)))  err_q[1] <= 1'b1;
      if (issue_in & ~issue_ok)                              err_q[2] <= 1'b1;
    end
  end

  assign err = err_q;
`else
  assign err = 3'b000;
`endif

endmodule

// File: doc/ldiv_result_buffer.md
Name: ldiv_result_buffer

Overview:
Downstream stage of the pipelined long divider. The divider pipeline has fixed latency and cannot stall, so this block provides the backpressure the divider lacks.
- Captures each quotient/remainder result into a FIFO.
- Presents results on a ready/valid master interface.
- Tracks in-flight divider operations and drives a credit signal (issue_ok) back to the issuer, so results are never dropped when the consumer stalls.

Parameters:
NUMERATOR_WIDTH, 23, width of remainder path (matches divider)
QUOTIENT_WIDTH, 23, width of quotient path (matches divider)
DEPTH, 16, FIFO entries; power of two, >= 2
CW, $clog2(DEPTH+1), width of count and in-flight counters (localparam)

Ports:
clk  in  1  clock
resetb  in  1  reset, asynchronous, active-low
issue_in  in  1  pulse: a request entered the divider this cycle (the divider's valid_in)
issue_ok  out  1  issuer may assert issue_in this cycle
div_quotient_in  in  QUOTIENT_WIDTH  divider quotient_out
div_remainder_in  in  NUMERATOR_WIDTH  divider remainder_out
div_valid_in  in  1  divider valid_out
m_quotient  out  QUOTIENT_WIDTH  head-of-FIFO quotient
m_remainder  out  NUMERATOR_WIDTH  head-of-FIFO remainder
m_valid  out  1  head entry valid
m_ready  in  1  consumer accepts head
count  out  CW  entries currently stored
in_flight  out  CW  issued requests not yet returned by divider
err  out  3  sticky error flags (see Optional Feature)

Behaviour:
- Reset (async, resetb low): count=0, in_flight=0, read/write pointers=0, m_valid=0, m_quotient=0, m_remainder=0, err=0. issue_ok=1 after reset.
- Reset mid-operation clears all state; stored results and in-flight accounting are discarded.
- push = div_valid_in. pop = m_valid & m_ready.
- issue_ok = (count + in_flight) < DEPTH, combinational from registers only; no path from issue_in.
- in_flight next value:
  - +1 on issue_in only.
  - -1 on div_valid_in only.
  - Unchanged when both or neither occur.
- count next value:
  - +1 on accepted push only.
  - -1 on pop only.
  - Unchanged on simultaneous accepted push and pop.
- Push when full:
  - Accepted if pop occurs the same cycle (slot frees).
  - Otherwise the data is dropped, count unchanged, and err[0] sets (if enabled).
- No empty bypass: push at cycle N into an empty FIFO gives m_valid=1 at N+1 with that data. Push and pop in the same cycle on an empty FIFO is impossible (m_valid=0).
- Output regs:
  - m_valid = (count != 0), registered.
  - m_quotient/m_remainder show the entry at the read pointer and update the cycle after a pop or after the first push into empty.
  - Data is held stable while m_valid & ~m_ready.
- Ordering: strict FIFO; results leave in divider completion order, which equals issue order.
- Pointers wrap modulo DEPTH with no bubble.
- Legal-use invariant: count + in_flight <= DEPTH at all times, so no overflow occurs if the issuer honours issue_ok.
- Throughput: one push and one pop per cycle sustained.

Optional Feature:
Macro LDIV_RESULT_BUFFER_ERR_EN.
- Defined: err is a set of sticky flags, cleared only by reset.
  - err[0] = push dropped on full FIFO.
  - err[1] = div_valid_in while in_flight==0 and no issue_in the same cycle; in_flight saturates at 0.
  - err[2] = issue_in while issue_ok==0; the issue is still counted, saturating at DEPTH.
- Undefined: err tied to 3'b000. No saturation logic; counters wrap.

Test Plan:
- Reset with resetb=0 mid-stream (count=5, in_flight=3) -> next cycle count=0, in_flight=0, m_valid=0, issue_ok=1, err=0.
- Single result q=0x00000A, r=0x3 with div_valid_in at cycle N and m_ready=1 -> m_valid=1 with q=0x00000A, r=0x3 at N+1; popped; m_valid=0 at N+2; count returns to 0.
- Credit stall: m_ready=0; issue 16 requests; divider returns all 16 after latency 24 -> issue_ok drops after the 16th issue; count=16, in_flight=0; no loss.
  - Then m_ready=1 for 16 cycles -> 16 results in issue order, and issue_ok=1 again.
- Full with simultaneous push+pop: count=16, div_valid_in=1, m_ready=1 -> count stays 16, new data stored, err[0]=0.
- Overflow (ERR_EN defined): count=16, m_ready=0, div_valid_in=1 -> data dropped, count=16, err[0]=1 sticky until reset.
- Protocol errors (ERR_EN defined):
  - issue_in while issue_ok=0 -> err[2]=1.
  - div_valid_in with in_flight=0 -> err[1]=1, in_flight stays 0.
  - Undefined build -> err=0.
